// File: rtl/dct_cos_term_gen.sv
// rtl/dct_cos_term_gen.sv - streaming 8x8 DCT cosine-term generator (folded 1-D table, 3-stage pipe).
// Optional orthonormal alpha scaling when DCT_COS_ALPHA_EN is defined.
module dct_cos_term_gen #(
   parameter int OUT_W     = 32,
   parameter int FRAC_BITS = 8,
   parameter int COS_BITS  = 14
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start_valid,
   output logic                    start_ready,
   input  logic [2:0]              k1,
   input  logic [2:0]              k2,
   input  logic                    col_major,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] cos_term,
   output logic [2:0]              out_n1,
   output logic [2:0]              out_n2,
   output logic                    out_last
);
   localparam int SHIFT = 2*COS_BITS - FRAC_BITS;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nx;

   logic [2:0] k1_q, k2_q;
   logic       cm_q;
   logic [2:0] outer_q, inner_q;
   logic       advance, issue, issue_last;
   logic [2:0] n1_iss, n2_iss;

   logic                s1_v, s1_last;
   logic signed [15:0]  s1_c1, s1_c2;
   logic [2:0]          s1_n1, s1_n2;
   logic                s2_v, s2_last;
   logic signed [31:0]  s2_p;
   logic [2:0]          s2_n1, s2_n2;
   logic [31:0]         p_mag, p_shift;
   logic signed [31:0]  term_c;

   // cos((2n+1)k*pi/16) in Q14, folded onto the quarter-wave table T[0..8]
   function automatic logic signed [15:0] cos_lut(input logic [2:0] n, input logic [2:0] k);
      logic [4:0]         m;
      logic [3:0]         idx;
      logic               neg;
      logic signed [15:0] mag;
      m = {1'b0, n, 1'b1} * {2'b00, k};
      if (m <= 5'd8) begin
         idx = m[3:0];
         neg = 1'b0;
      end else if (m <= 5'd16) begin
         idx = 4'(5'd16 - m);
         neg = 1'b1;
      end else if (m <= 5'd23) begin
         idx = 4'(m - 5'd16);
         neg = 1'b1;
      end else begin
         idx = 4'(6'd32 - {1'b0, m});
         neg = 1'b0;
      end
      case (idx)
         4'd0:    mag = 16'sd16384;
         4'd1:    mag = 16'sd16069;
         4'd2:    mag = 16'sd15137;
         4'd3:    mag = 16'sd13623;
         4'd4:    mag = 16'sd11585;
         4'd5:    mag = 16'sd9102;
         4'd6:    mag = 16'sd6270;
         4'd7:    mag = 16'sd3196;
         default: mag = 16'sd0;
      endcase
`ifdef DCT_COS_ALPHA_EN
      if (k == 3'd0) mag = 16'sd11585;
`else
`endif
      return neg ? -mag : mag;
   endfunction

   assign advance    = !out_valid || out_ready;
   assign issue      = (state == RUN) && advance;
   assign issue_last = (outer_q == 3'd7) && (inner_q == 3'd7);
   assign n1_iss     = cm_q ? inner_q : outer_q;
   assign n2_iss     = cm_q ? outer_q : inner_q;

   always_comb begin
      state_nx    = state;
      start_ready = (state == IDLE);
      case (state)
         IDLE:    if (start_valid) state_nx = RUN;
         RUN:     if (issue && issue_last) state_nx = DRAIN;
         DRAIN:   if (out_valid && out_ready && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k1_q    <= '0;
         k2_q    <= '0;
         cm_q    <= 1'b0;
         outer_q <= '0;
         inner_q <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start_valid) begin
            k1_q    <= k1;
            k2_q    <= k2;
            cm_q    <= col_major;
            outer_q <= '0;
            inner_q <= '0;
         end else if (issue) begin
            inner_q <= inner_q + 3'd1;
            if (inner_q == 3'd7) outer_q <= outer_q + 3'd1;
         end
      end
   end

   // Truncation toward zero: shift the magnitude, then restore the sign
   always_comb begin
      p_mag   = s2_p[31] ? 32'(-s2_p) : 32'(s2_p);
      p_shift = p_mag >> SHIFT;
      term_c  = s2_p[31] ? -$signed(p_shift) : $signed(p_shift);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v      <= 1'b0;
         s1_last   <= 1'b0;
         s1_c1     <= '0;
         s1_c2     <= '0;
         s1_n1     <= '0;
         s1_n2     <= '0;
         s2_v      <= 1'b0;
         s2_last   <= 1'b0;
         s2_p      <= '0;
         s2_n1     <= '0;
         s2_n2     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         cos_term  <= '0;
         out_n1    <= '0;
         out_n2    <= '0;
      end else if (advance) begin
         s1_v    <= issue;
         s1_last <= issue_last;
         s1_c1   <= cos_lut(n1_iss, k1_q);
         s1_c2   <= cos_lut(n2_iss, k2_q);
         s1_n1   <= n1_iss;
         s1_n2   <= n2_iss;
         s2_v    <= s1_v;
         s2_last <= s1_last;
         s2_p    <= 32'(s1_c1) * 32'(s1_c2);
         s2_n1   <= s1_n1;
         s2_n2   <= s1_n2;
         out_valid <= s2_v;
         out_last  <= s2_v && s2_last;
         if (s2_v) begin
            cos_term <= OUT_W'(term_c);
            out_n1   <= s2_n1;
            out_n2   <= s2_n2;
         end
      end
   end
endmodule

// File: tb/tb_dct_cos_term_gen.sv
// tb/tb_dct_cos_term_gen.sv - randomized self-checking bench for dct_cos_term_gen.
`timescale 1ns/1ps
module tb_dct_cos_term_gen;
   localparam int OUT_W     = 32;
   localparam int FRAC_BITS = 8;
`ifdef DCT_COS_ALPHA_EN
   localparam int DC_TERM = 127;
`else
   localparam int DC_TERM = 256;
`endif

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic                    start_valid = 1'b0;
   logic                    start_ready;
   logic [2:0]              k1 = '0, k2 = '0;
   logic                    col_major = 1'b0;
   logic                    out_valid;
   logic                    out_ready = 1'b1;
   logic signed [OUT_W-1:0] cos_term;
   logic [2:0]              out_n1, out_n2;
   logic                    out_last;

   dct_cos_term_gen #(.OUT_W(OUT_W), .FRAC_BITS(FRAC_BITS), .COS_BITS(14)) dut (
      .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
      .k1(k1), .k2(k2), .col_major(col_major), .out_valid(out_valid), .out_ready(out_ready),
      .cos_term(cos_term), .out_n1(out_n1), .out_n2(out_n2), .out_last(out_last)
   );

   always #5 clk = ~clk;

   typedef struct { int term; int n1; int n2; bit last; } exp_t;
   exp_t exp_q[$];
   exp_t cur_e;
   int   log_term[$], log_n1[$], log_n2[$];
   bit   log_last[$];
   int   n_vec = 0, n_err = 0, hs_cnt = 0, blk_base = 0;
   bit   rdy_rand = 1'b0;

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   function automatic int model_cos(int n, int k);
      int tbl [0:8];
      int m, v;
      tbl = '{16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196, 0};
      m = ((2*n + 1) * k) % 32;
      if (m <= 8)       v = tbl[m];
      else if (m <= 16) v = -tbl[16-m];
      else if (m <= 23) v = -tbl[m-16];
      else              v = tbl[32-m];
`ifdef DCT_COS_ALPHA_EN
      if (k == 0) v = 11585;
`endif
      return v;
   endfunction

   task automatic push_block(input int a, input int b, input bit cm);
      exp_t   e;
      longint p;
      for (int pos = 0; pos < 64; pos++) begin
         e.n1   = cm ? pos % 8 : pos / 8;
         e.n2   = cm ? pos / 8 : pos % 8;
         p      = longint'(model_cos(e.n1, a)) * longint'(model_cos(e.n2, b));
         e.term = int'(p / (longint'(1) << (28 - FRAC_BITS)));
         e.last = (pos == 63);
         exp_q.push_back(e);
      end
   endtask

   // Single compare process: every valid cycle must match the head of the model queue
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_valid", out_valid, 0);
         end else begin
            cur_e = exp_q[0];
            chk("stream_term", cos_term, cur_e.term);
            chk("stream_n1_n2_last", {out_n1, out_n2, out_last},
                {cur_e.n1[2:0], cur_e.n2[2:0], cur_e.last});
            if (out_ready) begin
               void'(exp_q.pop_front());
               log_term.push_back(int'(cos_term));
               log_n1.push_back(int'(out_n1));
               log_n2.push_back(int'(out_n2));
               log_last.push_back(out_last);
               hs_cnt++;
            end
         end
      end
   end

   always @(posedge clk) begin
      if (rdy_rand) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic start_block(input logic [2:0] a, input logic [2:0] b, input logic cm, input bit chk_lat);
      int t = 0;
      log_term.delete(); log_n1.delete(); log_n2.delete(); log_last.delete();
      @(negedge clk);
      while (!start_ready && t < 1000) begin @(negedge clk); t++; end
      chk("start_ready_wait", start_ready, 1);
      k1 = a; k2 = b; col_major = cm; start_valid = 1'b1;
      @(posedge clk);
      blk_base = hs_cnt;
      push_block(int'(a), int'(b), cm);
      #1;
      start_valid = 1'b0;
      k1 = 3'($urandom); k2 = 3'($urandom); col_major = 1'($urandom);
      if (chk_lat) begin
         chk("lat_e0", out_valid, 0);
         @(posedge clk); #1 chk("lat_e1", out_valid, 0);
         @(posedge clk); #1 chk("lat_e2", out_valid, 0);
         @(posedge clk); #1 chk("lat_e3", out_valid, 1);
      end
   endtask

   task automatic wait_block();
      int t = 0;
      while (hs_cnt < blk_base + 64 && t < 3000) begin @(negedge clk); #1; t++; end
      chk("block_handshakes", hs_cnt - blk_base, 64);
      if (hs_cnt == blk_base + 64) begin
         @(posedge clk); #1;
         chk("start_ready_after_last", start_ready, 1);
         chk("model_queue_empty", exp_q.size(), 0);
      end
   endtask

   initial begin
      int exp8 [0:7];
      int t;
      exp8 = '{246, 208, 139, 48, -48, -139, -208, -246};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_start_ready", start_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_cos_term", cos_term, 0);
      chk("rst_out_n1", out_n1, 0);
      chk("rst_out_n2", out_n2, 0);
      @(negedge clk) rst_n = 1'b1;

      start_block(3'd1, 3'd1, 1'b0, 1'b1);
      wait_block();
      for (int i = 0; i < 8; i++) chk("k11_row0", log_term[i], exp8[i]);
      chk("k11_term9", log_term[9], 176);
      chk("k11_term63", log_term[63], 246);
      chk("k11_last63", log_last[63], 1);

      start_block(3'd0, 3'd0, 1'b0, 1'b1);
      wait_block();
      for (int i = 0; i < 64; i++) chk("k00_term", log_term[i], DC_TERM);

      start_block(3'd1, 3'd1, 1'b0, 1'b0);
      t = 0;
      while (hs_cnt < blk_base + 10 && t < 200) begin @(negedge clk); #1; t++; end
      chk("bp_reach_term10", hs_cnt - blk_base, 10);
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1);
         chk("stall_term", cos_term, 118);
         chk("stall_n1_n2", {out_n1, out_n2}, {3'd1, 3'd2});
      end
      @(posedge clk); #1 out_ready = 1'b1;
      wait_block();

      start_block(3'd4, 3'd4, 1'b1, 1'b1);
      wait_block();
      chk("cm_term0", log_term[0], 127);
      chk("cm_term1", log_term[1], -127);
      chk("cm_idx1", {log_n1[1], log_n2[1]}, {32'd1, 32'd0});
      chk("cm_idx8", {log_n1[8], log_n2[8]}, {32'd0, 32'd1});

      start_block(3'd2, 3'd3, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      chk("busy_start_ready", start_ready, 0);
      start_valid = 1'b1; k1 = 3'd7; k2 = 3'd7;
      @(posedge clk); #1 start_valid = 1'b0;
      wait_block();

      rdy_rand = 1'b1;
      repeat (6) begin
         start_block(3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
         wait_block();
      end

      start_block(3'($urandom), 3'($urandom), 1'($urandom), 1'b0);
      t = 0;
      while (hs_cnt < blk_base + 20 && t < 500) begin @(negedge clk); #1; t++; end
      chk("midrst_progress", hs_cnt - blk_base, 20);
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_out_last", out_last, 0);
      chk("midrst_cos_term", cos_term, 0);
      chk("midrst_start_ready", start_ready, 1);
      exp_q.delete();
      rdy_rand = 1'b0;
      repeat (2) @(negedge clk);
      out_ready = 1'b1;
      rst_n = 1'b1;
      start_block(3'd3, 3'd5, 1'b0, 1'b1);
      wait_block();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/dct_cos_term_gen.md
Name: dct_cos_term_gen

Overview:
- Parametrised, streaming successor to the fixed per-(k1,k2) 8x8 DCT cosine-term LUTs.
- On a start request it latches any (k1,k2) in 0..7 and emits all 64 products cos((2n1+1)k1π/16)·cos((2n2+1)k2π/16), scaled by 2^FRAC_BITS.
- Output is a valid/ready stream with a last flag, feeding the DCT multiply-accumulate stage.
- Replaces 64 separate LUT modules with one folded 1-D table, a multiplier and a 3-stage pipeline.

Parameters:
- OUT_W, 32: output width; signed two's complement.
- FRAC_BITS, 8: output fractional bits; legal range 1..14. FRAC_BITS=8 matches the legacy LUT scale, e.g. 246 = 0x0f6.
- COS_BITS, 14: fractional bits of the 1-D cosine table; fixed at 14.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_valid  in  1  request to generate one block.
- start_ready  out  1  high when idle and able to accept a request.
- k1  in  3  vertical frequency index; sampled on the start handshake.
- k2  in  3  horizontal frequency index; sampled on the start handshake.
- col_major  in  1  scan order select; 0 = n1 outer loop, 1 = n2 outer loop. Sampled on the start handshake.
- out_valid  out  1  cos_term is valid.
- out_ready  in  1  downstream accept.
- cos_term  out  OUT_W  signed scaled product.
- out_n1  out  3  n1 index of the current term.
- out_n2  out  3  n2 index of the current term.
- out_last  out  1  high on the 64th term of the block.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous assert, active low. Synchronous deassert is provided externally.
- Reset values:
  - start_ready = 1.
  - out_valid = 0, out_last = 0.
  - cos_term = 0, out_n1 = 0, out_n2 = 0.
  - Scan counters = 0, FSM = IDLE.
  - All pipeline valid bits = 0.
- Cosine table: T[0..8] = 16384, 16069, 15137, 13623, 11585, 9102, 6270, 3196, 0.
- Index folding: m = ((2n+1)·k) mod 32, giving value c:
  - m ≤ 8: c = +T[m].
  - 9 ≤ m ≤ 16: c = −T[16−m].
  - 17 ≤ m ≤ 23: c = −T[m−16].
  - 24 ≤ m ≤ 31: c = +T[32−m].
- Product: p = c1·c2, exact and signed (30 bits are sufficient).
  - cos_term = sign(p) · (|p| >> (28−FRAC_BITS)), i.e. truncation toward zero.
  - Result is sign-extended to OUT_W.
- FSM:
  - IDLE: start_ready=1. On start_valid, latch k1/k2/col_major, clear counters, go to RUN.
  - RUN: issue one (n1,n2) into the pipeline per non-stalled cycle. Inner index increments; on wrap 7→0 the outer index increments. After issuing index 63, go to DRAIN.
  - DRAIN: wait until the pipeline is empty and the last term has handshaken, then go to IDLE.
- Pipeline stages:
  - S1: fold and lookup c1, c2, register them.
  - S2: multiply, register.
  - S3: shift and sign, register onto the outputs.
- Latency: with out_ready held high, the first out_valid occurs 3 cycles after the start handshake cycle. Terms 1..64 appear on consecutive cycles.
- Stall: the whole pipeline and the issue counter freeze while out_valid && !out_ready.
  - All outputs are held stable during the stall.
  - No term is dropped or duplicated.
- out_last is asserted only with the term whose scan position is 63.
- start_valid while not in IDLE: ignored, since start_ready=0.
- Back-to-back blocks: start_ready rises in the cycle after the last handshake.
- Reset mid-block: all state clears immediately and no partial outputs remain. After reset, a new start behaves like the first request.

Optional Feature:
- Macro name: DCT_COS_ALPHA_EN.
- Defined: orthonormal α scaling is folded in. Any factor whose k is 0 uses 11585 (1/√2) instead of T[0] = 16384, so k1=k2=0 gives 127.
- Undefined: no α scaling; k1=k2=0 gives 256. The block is bit-exact with the legacy LUT scale.

Test Plan:
- Reset mid-stream: assert rst_n low mid-block -> out_valid, out_last and cos_term read 0 immediately and start_ready=1. A new start then produces a full 64-term block.
- k1=1, k2=1, col_major=0, out_ready=1 -> terms 246, 208, 139, 48, −48, −139, −208, −246 for n1=0.
  - Term index 9 (n1=1, n2=1) is 176.
  - The 64th term is 246 with out_last=1.
  - First out_valid arrives 3 cycles after the start handshake.
- k1=0, k2=0 -> all 64 terms are 256 without DCT_COS_ALPHA_EN, and 127 with it.
- Backpressure: k1=1, k2=1; drop out_ready for 5 cycles while term 10 is presented -> cos_term, out_n1 and out_n2 stay stable. The remaining sequence continues unchanged, for exactly 64 handshakes in total.
- Column-major order: k1=4, k2=4, col_major=1 -> first term is 127 at (0,0), then −127 at (n1=1, n2=0). The out_n1/out_n2 sequence follows column-major order.
- Busy start: pulse start_valid during RUN with k1=7 -> start_ready=0, the request is ignored and the current block completes unaltered.
